regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter N_REGS, default 32: number of architectural registers, legal range 2..64.
REQ-002 The block SHALL have parameter R_WIDTH, default 32: register width in bits.
REQ-003 The block SHALL have parameter N_RD, default 2: number of read ports, legal range 1..4.
REQ-004 The block SHALL have parameter N_WR, default 1: number of write ports, legal range 1..2.
REQ-005 The block SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero and is never busy.
REQ-006 The block SHALL have derived localparam W_ADDR = $clog2(N_REGS), which is not overridable.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-009 The block SHALL have port wr_en, input, [N_WR]: write strobe per write port.
REQ-010 The block SHALL have port wr_addr, input, [N_WR][W_ADDR]: write address per write port.
REQ-011 The block SHALL have port wr_data, input, [N_WR][R_WIDTH]: write data per write port.
REQ-012 The block SHALL have port rd_en, input, [N_RD]: read strobe per read port.
REQ-013 The block SHALL have port rd_addr, input, [N_RD][W_ADDR]: read address per read port.
REQ-014 The block SHALL have port rd_data, output, [N_RD][R_WIDTH]: registered read data.
REQ-015 The block SHALL have port rd_busy, output, [N_RD]: registered busy (pending-write) flag for the read register.
REQ-016 The block SHALL have port rsv_en, input, 1 bit: reserve strobe, which marks a destination register busy.
REQ-017 The block SHALL have port rsv_addr, input, [W_ADDR]: register to reserve.
REQ-018 The block SHALL have port addr_err, output, 1 bit: one-cycle pulse on any out-of-range enabled access.
REQ-019 The block SHALL have port err_sticky, output, 1 bit: sticky OR of addr_err.
REQ-020 The block SHALL have port err_clr, input, 1 bit: clears err_sticky.

Function
REQ-021 Read latency SHALL be exactly 1 cycle: rd_en[i] high at edge k loads rd_data[i] and rd_busy[i] at edge k.
REQ-022 rd_data[i] and rd_busy[i] SHALL hold their previous values while rd_en[i] is low.
REQ-023 Forwarding: a read whose address matches an enabled in-range write in the same cycle SHALL return that write's wr_data, and rd_busy SHALL be 0 unless rsv_en targets the same address.
REQ-024 Write conflict: when both write ports target the same address, port N_WR-1 SHALL win for storage and for forwarding.
REQ-025 With ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0 with rd_busy=0, and reserves of address 0 SHALL be ignored.
REQ-026 Scoreboard: rsv_en SHALL set busy[rsv_addr], and an enabled in-range write SHALL clear busy[wr_addr].
REQ-027 Simultaneous reserve and write to the same address SHALL leave busy set (reserve wins) while the data is still written.
REQ-028 An address with value N_REGS or greater on an enabled port SHALL suppress that access: no storage or scoreboard change, and rd_data/rd_busy hold.
REQ-029 An out-of-range address on an enabled port SHALL raise addr_err for one cycle at the next edge.
REQ-030 Out-of-range checking SHALL apply only when N_REGS is not a power of two; otherwise addr_err stays 0.
REQ-031 err_sticky SHALL set when addr_err is produced and clear when err_clr is high; if both occur in the same cycle, set SHALL win.
REQ-032 Disabled ports SHALL never raise addr_err, whatever their address value.

Reset
REQ-033 While rst_n is low, all storage, busy bits, rd_data, rd_busy, addr_err and err_sticky SHALL be 0, asynchronously.
REQ-034 After rst_n deasserts, the first edge SHALL behave normally, and no access issued before that edge SHALL take effect.
REQ-035 If reset asserts mid-operation, pending reserves SHALL be discarded (no residual busy bits).

Structure
REQ-036 Package regfile_pkg SHALL hold the parameter defaults, legal-range limits and the addr/data typedef helpers.
REQ-037 Sub-module regfile_scoreboard SHALL own the busy vector, reserve/clear priority and busy lookup; the datapath stays in regfile_mp.
REQ-038 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-039 Reset: with rst_n low, drive all enables -> all outputs stay 0; after release, read r5 -> rd_data=0, rd_busy=0.
REQ-040 Forwarding: write r3=0xDEADBEEF and read r3 on both ports in the same cycle -> next cycle both rd_data=0xDEADBEEF.
REQ-041 Write conflict: N_WR=2, port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle -> a later read gives 0x22.
REQ-042 Scoreboard: reserve r9, read r9 -> rd_busy=1; write r9 plus reserve r9 in the same cycle -> busy stays 1; write r9 alone -> busy cleared, read gives rd_busy=0.
REQ-043 Zero register: write r0=0xFF, reserve r0, read r0 -> rd_data=0, rd_busy=0.
REQ-044 Error: N_REGS=24, write address 30 -> storage unchanged, addr_err pulses one cycle, err_sticky=1; err_clr together with a new error -> err_sticky stays 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, legal parameter limits and address/data helpers for the multi-port register file.
// Pure declarations: no latency, no state.
// No flow control lives here; consumers apply their own.
package regfile_pkg;

    localparam int N_REGS_DEF   = 32;
    localparam int R_WIDTH_DEF  = 32;
    localparam int N_RD_DEF     = 2;
    localparam int N_WR_DEF     = 1;
    localparam int ZERO_REG_DEF = 1;

    localparam int N_REGS_MIN = 2;
    localparam int N_REGS_MAX = 64;
    localparam int N_RD_MIN   = 1;
    localparam int N_RD_MAX   = 4;
    localparam int N_WR_MIN   = 1;
    localparam int N_WR_MAX   = 2;

    localparam int ADDR_W_MAX = $clog2(N_REGS_MAX);

    typedef logic [ADDR_W_MAX-1:0]  addr_max_t;
    typedef logic [R_WIDTH_DEF-1:0] data_t;

    // With a power-of-two register count every encodable address is legal,
    // so this can never flag an error in that case.
    function automatic logic addr_in_range(input addr_max_t addr, input int n_regs);
        return int'(addr) < n_regs;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy (pending-write) scoreboard: reserve sets, write clears, reserve wins on collision.
// Lookup is combinational on the pre-edge state, with same-cycle write/reserve override.
// No backpressure: set/clear strobes are accepted every cycle.
module regfile_scoreboard #(
    parameter int N_RD   = 2,
    parameter int N_WR   = 1,
    parameter int W_ADDR = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         set_vld,
    input  logic [W_ADDR-1:0]            set_addr,
    input  logic [N_WR-1:0]              clr_vld,
    input  logic [N_WR-1:0][W_ADDR-1:0]  clr_addr,
    input  logic [N_RD-1:0][W_ADDR-1:0]  lk_addr,
    output logic [N_RD-1:0]              lk_busy
);

    localparam int DEPTH = 1 << W_ADDR;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < N_WR; j++) begin
            if (clr_vld[j]) busy_nxt[clr_addr[j]] = 1'b0;
        end
        if (set_vld) busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    // A write landing this cycle makes the register ready unless it is re-reserved.
    always_comb begin
        lk_busy = '0;
        for (int i = 0; i < N_RD; i++) begin
            lk_busy[i] = busy[lk_addr[i]];
            for (int j = 0; j < N_WR; j++) begin
                if (clr_vld[j] && (clr_addr[j] == lk_addr[i]))
                    lk_busy[i] = set_vld && (set_addr == lk_addr[i]);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write forwarding, busy scoreboard and address error reporting.
// Read data and busy are registered: 1-cycle latency; outputs hold when a read port is idle.
// No backpressure: every port accepts an access every cycle.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int N_REGS   = N_REGS_DEF,
    parameter int R_WIDTH  = R_WIDTH_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int N_WR     = N_WR_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    localparam int W_ADDR  = $clog2(N_REGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_WR-1:0]               wr_en,
    input  logic [N_WR-1:0][W_ADDR-1:0]   wr_addr,
    input  logic [N_WR-1:0][R_WIDTH-1:0]  wr_data,
    input  logic [N_RD-1:0]               rd_en,
    input  logic [N_RD-1:0][W_ADDR-1:0]   rd_addr,
    output logic [N_RD-1:0][R_WIDTH-1:0]  rd_data,
    output logic [N_RD-1:0]               rd_busy,
    input  logic                          rsv_en,
    input  logic [W_ADDR-1:0]             rsv_addr,
    output logic                          addr_err,
    output logic                          err_sticky,
    input  logic                          err_clr
);

    localparam int DEPTH = 1 << W_ADDR;

    if (N_REGS < N_REGS_MIN || N_REGS > N_REGS_MAX || N_RD < N_RD_MIN || N_RD > N_RD_MAX ||
        N_WR < N_WR_MIN || N_WR > N_WR_MAX || R_WIDTH < 1 || ZERO_REG < 0 || ZERO_REG > 1)
    begin : g_bad_params
        $error("regfile_mp: illegal parameter value");
    end

    function automatic logic in_range(input logic [W_ADDR-1:0] a);
        return addr_in_range(addr_max_t'(a), N_REGS);
    endfunction

    function automatic logic is_zero_reg(input logic [W_ADDR-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    logic [N_WR-1:0] wr_ok;
    logic [N_RD-1:0] rd_ok;
    logic            rsv_ok;
    logic            err_now;

    always_comb begin
        wr_ok   = '0;
        rd_ok   = '0;
        rsv_ok  = 1'b0;
        err_now = 1'b0;
        for (int j = 0; j < N_WR; j++) begin
            wr_ok[j] = wr_en[j] && in_range(wr_addr[j]) && !is_zero_reg(wr_addr[j]);
            err_now  = err_now | (wr_en[j] && !in_range(wr_addr[j]));
        end
        for (int i = 0; i < N_RD; i++) begin
            rd_ok[i] = rd_en[i] && in_range(rd_addr[i]);
            err_now  = err_now | (rd_en[i] && !in_range(rd_addr[i]));
        end
        rsv_ok  = rsv_en && in_range(rsv_addr) && !is_zero_reg(rsv_addr);
        err_now = err_now | (rsv_en && !in_range(rsv_addr));
    end

    // Entries at or above N_REGS are never written and stay at their reset value.
    logic [R_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < N_WR; j++) begin
                if (wr_ok[j]) mem[wr_addr[j]] <= wr_data[j];
            end
        end
    end

    // Later write ports override earlier ones for forwarding, matching storage order.
    logic [N_RD-1:0][R_WIDTH-1:0] rd_fwd;

    always_comb begin
        rd_fwd = '0;
        for (int i = 0; i < N_RD; i++) begin
            rd_fwd[i] = mem[rd_addr[i]];
            for (int j = 0; j < N_WR; j++) begin
                if (wr_ok[j] && (wr_addr[j] == rd_addr[i])) rd_fwd[i] = wr_data[j];
            end
        end
    end

    logic [N_RD-1:0] lk_busy;

    regfile_scoreboard #(
        .N_RD   (N_RD),
        .N_WR   (N_WR),
        .W_ADDR (W_ADDR)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_vld  (rsv_ok),
        .set_addr (rsv_addr),
        .clr_vld  (wr_ok),
        .clr_addr (wr_addr),
        .lk_addr  (rd_addr),
        .lk_busy  (lk_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data    <= '0;
            rd_busy    <= '0;
            addr_err   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < N_RD; i++) begin
                if (rd_ok[i]) begin
                    rd_data[i] <= rd_fwd[i];
                    rd_busy[i] <= lk_busy[i];
                end
            end
            addr_err <= err_now;
            if (err_now)      err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
        end
    end

endmodule
